// File: rtl/bls12_381_pkg.sv
// BLS12-381 field types plus the Fp12 stream framing shared by (de)serializers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: fe_t (381-bit Fp word), fe12_t ([i][j][k] Fp12 element), beat count and
// byte width of one Fp12 stream burst, the serializer FSM state type, and the
// beat-index <-> [i][j][k] mapping so both stream directions share one definition.
package bls12_381_pkg;

    localparam int FE_BITS           = 381;
    localparam int FE12_STREAM_BEATS = 12;
    localparam int FE_STREAM_BYTS    = 48;

    typedef logic [FE_BITS-1:0] fe_t;

    // Indexed [i][j][k]: i = Fp6 half, j = Fp2 coefficient, k = Fp component.
    typedef fe_t [1:0][2:0][1:0] fe12_t;

    typedef struct packed {
        logic       i;
        logic [1:0] j;
        logic       k;
    } fe12_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fe12_ser_state_e;

    // Beat n carries word [i][j][k] with n = i*6 + j*2 + k.
    function automatic fe12_idx_t fe12_beat_idx(input logic [3:0] beat);
        fe12_idx_t  r;
        logic [2:0] rem;
        r.i = (beat >= 4'd6);
        rem = r.i ? 3'(beat - 4'd6) : beat[2:0];
        r.j = rem[2:1];
        r.k = rem[0];
        return r;
    endfunction

    function automatic fe_t fe12_word(input fe12_t a, input logic [3:0] beat);
        fe12_idx_t b;
        b = fe12_beat_idx(beat);
        return a[b.i][b.j][b.k];
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Generic AXI-stream style bundle: data, valid/ready, packet framing, side-band control.
// Latency: n/a (wires only).
// Backpressure: sink drives rdy; a beat transfers on val && rdy.
// Ports (signals): dat, val, rdy, sop, eop, err, mod (unused bytes in last word,
// 0 = all valid), ctl. Modports: source, sink.
interface if_axi_stream #(
    parameter int DAT_BYTS = 48,
    parameter int CTL_BITS = 64
);
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic [DAT_BYTS*8-1:0] dat;
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [MOD_BITS-1:0]   mod;
    logic [CTL_BITS-1:0]   ctl;

    modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
    modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);

endinterface

// File: rtl/ec_fe12_stream_ser.sv
// Serializes one parallel Fp12 element + control word into a 12-beat stream burst.
// Latency: first beat valid the cycle after capture; 12 beats back-to-back when rdy=1.
// Backpressure: outputs hold while rdy=0; o_rdy=0 during SEND (single buffer) or
// o_rdy=!buffer2_full (FE12_SER_DBL_BUF_EN defined: second holding buffer, no gap).
// Ports: i_clk, i_rst (async, active-low), i_val/o_rdy/i_fe12/i_ctl parallel input,
// o_fe12_if stream source (dat[380:0]=word, dat[383:381]=0, sop/eop framing, ctl per beat).
module ec_fe12_stream_ser
    import bls12_381_pkg::*;
#(
    parameter type FE_TYPE   = fe_t,
    parameter type FE12_TYPE = fe12_t,
    parameter int  CTL_BITS  = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_val,
    output logic                o_rdy,
    input  FE12_TYPE            i_fe12,
    input  logic [CTL_BITS-1:0] i_ctl,
    if_axi_stream.source        o_fe12_if
);

    localparam logic [3:0] LAST_BEAT = 4'(FE12_STREAM_BEATS - 1);
    localparam int         PAD_BITS  = FE_STREAM_BYTS * 8 - $bits(FE_TYPE);

    fe12_ser_state_e     state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    FE12_TYPE            act_fe12_q, act_fe12_d;
    logic [CTL_BITS-1:0] act_ctl_q, act_ctl_d;
    FE_TYPE              dat_q, dat_d;
    logic                val_q, val_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                rdy_q, rdy_d;

    logic                cap;
    logic                hs;
    logic                load;
    FE12_TYPE            load_fe12;
    logic [CTL_BITS-1:0] load_ctl;

`ifdef FE12_SER_DBL_BUF_EN
    FE12_TYPE            buf_fe12_q, buf_fe12_d;
    logic [CTL_BITS-1:0] buf_ctl_q, buf_ctl_d;
    logic                buf_full_q, buf_full_d;
    logic                cap_direct;
`endif

    assign cap = i_val && rdy_q;
    assign hs  = val_q && o_fe12_if.rdy;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        act_fe12_d = act_fe12_q;
        act_ctl_d  = act_ctl_q;
        dat_d      = dat_q;
        val_d      = val_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        load       = 1'b0;
        load_fe12  = i_fe12;
        load_ctl   = i_ctl;
`ifdef FE12_SER_DBL_BUF_EN
        buf_fe12_d = buf_fe12_q;
        buf_ctl_d  = buf_ctl_q;
        buf_full_d = buf_full_q;
        cap_direct = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                load = cap;
            end
            ST_SEND: begin
                if (hs) begin
                    if (idx_q == LAST_BEAT) begin
`ifdef FE12_SER_DBL_BUF_EN
                        if (buf_full_q) begin
                            load       = 1'b1;
                            load_fe12  = buf_fe12_q;
                            load_ctl   = buf_ctl_q;
                            buf_full_d = 1'b0;
                        end else if (cap) begin
                            // Capture coinciding with the final beat skips buffer2.
                            load       = 1'b1;
                            cap_direct = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            val_d   = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end
`else
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        val_d   = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                        dat_d = fe12_word(act_fe12_q, idx_d);
                        sop_d = 1'b0;
                        eop_d = (idx_d == LAST_BEAT);
                    end
                end
`ifdef FE12_SER_DBL_BUF_EN
                if (cap && !cap_direct) begin
                    buf_fe12_d = i_fe12;
                    buf_ctl_d  = i_ctl;
                    buf_full_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Start of a new burst: beat 0 is registered straight from the source element.
        if (load) begin
            state_d    = ST_SEND;
            idx_d      = '0;
            act_fe12_d = load_fe12;
            act_ctl_d  = load_ctl;
            dat_d      = fe12_word(load_fe12, 4'd0);
            val_d      = 1'b1;
            sop_d      = 1'b1;
            eop_d      = 1'b0;
        end

`ifdef FE12_SER_DBL_BUF_EN
        rdy_d = !buf_full_d;
`else
        rdy_d = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            act_fe12_q <= '0;
            act_ctl_q  <= '0;
            dat_q      <= '0;
            val_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            act_fe12_q <= act_fe12_d;
            act_ctl_q  <= act_ctl_d;
            dat_q      <= dat_d;
            val_q      <= val_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef FE12_SER_DBL_BUF_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            buf_fe12_q <= '0;
            buf_ctl_q  <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_fe12_q <= buf_fe12_d;
            buf_ctl_q  <= buf_ctl_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign o_rdy         = rdy_q;
    assign o_fe12_if.val = val_q;
    assign o_fe12_if.sop = sop_q;
    assign o_fe12_if.eop = eop_q;
    assign o_fe12_if.err = 1'b0;
    assign o_fe12_if.mod = '0;
    assign o_fe12_if.dat = {{PAD_BITS{1'b0}}, dat_q};
    assign o_fe12_if.ctl = act_ctl_q;

endmodule

// File: tb/tb_ec_fe12_stream_ser.sv
// Self-checking bench for ec_fe12_stream_ser: scoreboard queue filled at issue time,
// monitor pops on every val&&rdy handshake and checks stability during stalls.
// Covers reset state, single burst, random backpressure, back-to-back, reset mid-burst.
module tb_ec_fe12_stream_ser;
    import bls12_381_pkg::*;

    localparam logic [63:0] ATE_X = 64'hd201000000010000;
`ifdef FE12_SER_DBL_BUF_EN
    localparam int B2B_CYC = 24;
`else
    localparam int B2B_CYC = 25;
`endif

    typedef struct packed {
        logic [383:0] dat;
        logic         sop;
        logic         eop;
        logic [63:0]  ctl;
    } beat_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        i_val  = 1'b0;
    logic        o_rdy;
    fe12_t       i_fe12 = '0;
    logic [63:0] i_ctl  = '0;

    if_axi_stream #(.DAT_BYTS(48), .CTL_BITS(64)) s_if ();

    ec_fe12_stream_ser #(.CTL_BITS(64)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_val    (i_val),
        .o_rdy    (o_rdy),
        .i_fe12   (i_fe12),
        .i_ctl    (i_ctl),
        .o_fe12_if(s_if)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    last_eop_edge = 0;
    bit    rdy_rand = 1'b0;

    function automatic void chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Pattern 0: 16*n+1; 1: mixed bytes; 2: inverse of 1; 3: top bit set.
    function automatic fe12_t mk(input int mode);
        fe12_t a;
        fe_t   w;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 2; k++) begin
                    int n;
                    n = i * 6 + j * 2 + k;
                    case (mode)
                        0:       w = fe_t'(16 * n + 1);
                        1:       w = fe_t'({12{(32'(n) * 32'h01010101) ^ 32'hC3A55A3C}});
                        2:       w = ~fe_t'({12{(32'(n) * 32'h01010101) ^ 32'hC3A55A3C}});
                        default: w = {1'b1, 380'(n * 7 + 3)};
                    endcase
                    a[i][j][k] = w;
                end
        return a;
    endfunction

    task automatic push_elem(input fe12_t a, input logic [63:0] c);
        beat_t b;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 2; k++) begin
                    b.dat = {3'b000, a[i][j][k]};
                    b.sop = (i == 0 && j == 0 && k == 0);
                    b.eop = (i == 1 && j == 2 && k == 1);
                    b.ctl = c;
                    sb.push_back(b);
                end
    endtask

    task automatic send_elem(input fe12_t a, input logic [63:0] c, output int cap_edge);
        bit got;
        got = 1'b0;
        push_elem(a, c);
        i_fe12 = a;
        i_ctl  = c;
        i_val  = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = o_rdy;
            @(posedge clk);
            #1;
        end
        i_val    = 1'b0;
        cap_edge = cyc;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: o_rdy stayed 0 for 200 cycles");
        end
    endtask

    task automatic wait_drain(input int maxc);
        for (int t = 0; t < maxc && sb.size() != 0; t++) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        s_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.rdy = rdy_rand ? ($urandom_range(9, 0) < 3) : 1'b1;
        end
    end

    // Monitor
    initial begin
        beat_t hold;
        beat_t e;
        bit    hold_vld;
        hold_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_vld && s_if.val) begin
                chk("stall_dat", s_if.dat, hold.dat);
                chk("stall_sop", 384'(s_if.sop), 384'(hold.sop));
                chk("stall_eop", 384'(s_if.eop), 384'(hold.eop));
                chk("stall_ctl", 384'(s_if.ctl), 384'(hold.ctl));
            end
            hold_vld = 1'b0;
            if (s_if.val && !s_if.rdy) begin
                hold_vld = 1'b1;
                hold     = '{dat: s_if.dat, sop: s_if.sop, eop: s_if.eop, ctl: s_if.ctl};
            end else if (s_if.val && s_if.rdy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got dat %h, want no beat", s_if.dat);
                end else begin
                    e = sb.pop_front();
                    chk("beat_dat", s_if.dat, e.dat);
                    chk("beat_sop", 384'(s_if.sop), 384'(e.sop));
                    chk("beat_eop", 384'(s_if.eop), 384'(e.eop));
                    chk("beat_ctl", 384'(s_if.ctl), 384'(e.ctl));
                    chk("beat_mod", 384'(s_if.mod), 384'(0));
                    chk("beat_err", 384'(s_if.err), 384'(0));
                    if (s_if.eop) last_eop_edge = cyc + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int    ce;
        int    ce0;
        fe12_t a3;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 384'(s_if.val), 384'(0));
        chk("rst_sop", 384'(s_if.sop), 384'(0));
        chk("rst_eop", 384'(s_if.eop), 384'(0));
        chk("rst_err", 384'(s_if.err), 384'(0));
        chk("rst_mod", 384'(s_if.mod), 384'(0));
        chk("rst_dat", s_if.dat, 384'(0));
        chk("rst_ctl", 384'(s_if.ctl), 384'(0));
        chk("rst_rdy", 384'(o_rdy), 384'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_clk", 384'(o_rdy), 384'(0));
        @(posedge clk);
        #1;
        chk("rdy_after_clk", 384'(o_rdy), 384'(1));

        // Single element, rdy high
        send_elem(mk(0), ATE_X, ce);
        chk("first_val", 384'(s_if.val), 384'(1));
        chk("first_sop", 384'(s_if.sop), 384'(1));
        chk("first_dat", s_if.dat, 384'(1));
`ifdef FE12_SER_DBL_BUF_EN
        chk("rdy_in_send", 384'(o_rdy), 384'(1));
`else
        chk("rdy_in_send", 384'(o_rdy), 384'(0));
`endif
        wait_drain(40);

        // Random backpressure
        rdy_rand = 1'b1;
        send_elem(mk(1), 64'h0123_4567_89ab_cdef, ce);
        send_elem(mk(3), ~ATE_X, ce);
        wait_drain(400);
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_bp", 384'(s_if.val), 384'(0));

        // Back-to-back
        send_elem(mk(2), ATE_X, ce0);
        send_elem(mk(0), 64'h5, ce);
        wait_drain(60);
        chk("b2b_cycles", 384'(last_eop_edge - ce0), 384'(B2B_CYC));

        // Reset mid-burst
        repeat (2) @(posedge clk);
        #1;
        a3 = mk(3);
        send_elem(a3, ATE_X, ce);
        repeat (5) @(posedge clk);
        #1;
        chk("beat5_on_bus", s_if.dat, {3'b000, a3[0][2][1]});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_val", 384'(s_if.val), 384'(0));
        chk("async_rst_dat", s_if.dat, 384'(0));
        chk("async_rst_rdy", 384'(o_rdy), 384'(0));
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rerst", 384'(o_rdy), 384'(1));
        send_elem(mk(1), ATE_X, ce);
        chk("restart_sop", 384'(s_if.sop), 384'(1));
        wait_drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
